issue_checker: RTL and testbench

ISSUE_CHECKER -- requirements
Module: issue_checker

---
 rtl/issue_checker.sv | 154 +++++++++++++++
 tb/tb_issue_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_checker.sv
`default_nettype none
// ============================================================================
// Module      : issue_checker
// Description : Exhaustive stimulus sweeper that compares a device-under-test
//               response against a golden model for every stimulus value,
//               counting mismatches and capturing the first failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_checker #(
  parameter int AW     = 4,
  parameter int YW     = 16,
  parameter int CW     = 8,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] a,
  input  logic [YW-1:0] y_dut,
  input  logic [YW-1:0] y_ref,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_cnt,
  output logic [AW-1:0] fail_a,
  output logic [YW-1:0] fail_diff
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] A_LAST    = {AW{1'b1}};
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [3:0]    HOLD_LAST = 4'(SETTLE - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] a_q, a_d;
  logic [3:0]    hold_q, hold_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [AW-1:0] fail_a_q, fail_a_d;
  logic [YW-1:0] fail_diff_q, fail_diff_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic [YW-1:0] diff;
  logic          compare;

  assign diff    = y_dut ^ y_ref;
  assign compare = (hold_q == HOLD_LAST);

  // Next-state and result-update logic; abort outranks a same-cycle compare.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    hold_d      = hold_q;
    err_cnt_d   = err_cnt_q;
    fail_a_d    = fail_a_q;
    fail_diff_d = fail_diff_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          a_d         = '0;
          hold_d      = '0;
          err_cnt_d   = '0;
          fail_a_d    = '0;
          fail_diff_d = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (compare) begin
          if (diff != '0) begin
            // Only the first failing vector is recorded.
            if (err_cnt_q == '0) begin
              fail_a_d    = a_q;
              fail_diff_d = diff;
            end
            if (err_cnt_q != CNT_MAX) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
          hold_d = '0;
          if (a_q == A_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end else begin
            a_d = a_q + 1'b1;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      hold_q      <= '0;
      err_cnt_q   <= '0;
      fail_a_q    <= '0;
      fail_diff_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      hold_q      <= hold_d;
      err_cnt_q   <= err_cnt_d;
      fail_a_q    <= fail_a_d;
      fail_diff_q <= fail_diff_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign a         = a_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign fail_a    = fail_a_q;
  assign fail_diff = fail_diff_q;

endmodule
`default_nettype wire

// File: tb/tb_issue_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_checker
// Description : Self-checking bench for issue_checker; two instances cover
//               SETTLE=1/CW=8 and SETTLE=3/CW=2. Expected sweep results are
//               queued at start and compared when done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_checker;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        s1_start = 1'b0, s1_abort = 1'b0;
  logic        s3_start = 1'b0, s3_abort = 1'b0;
  int          mode1 = 0, mode3 = 0;

  logic [3:0]  a1, a3, fa1, fa3;
  logic [15:0] yd1, yr1, yd3, yr3, fd1, fd3;
  logic        busy1, done1, pass1, busy3, done3, pass3;
  logic [7:0]  ec1;
  logic [1:0]  ec3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int cycles;
    int pass;
    int err;
    int fa;
    int fd;
  } exp_t;
  exp_t sb_q[$];

  function automatic logic [15:0] yref_of(logic [3:0] av);
    return {av, ~av, av ^ 4'h9, av + 4'h3};
  endfunction

  function automatic logic [15:0] mask_of(int mode, logic [3:0] av);
    case (mode)
      1:       return (av == 4'd5) ? 16'h0004 : 16'h0000;
      2:       return 16'hFFFF;
      3:       return (av == 4'd15) ? 16'h0081 : 16'h0000;
      4:       return (av == 4'd3 || av == 4'd7) ? 16'h0010 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  assign yr1 = yref_of(a1);
  assign yd1 = yr1 ^ mask_of(mode1, a1);
  assign yr3 = yref_of(a3);
  assign yd3 = yr3 ^ mask_of(mode3, a3);

  issue_checker #(.AW(4), .YW(16), .CW(8), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .abort(s1_abort), .a(a1),
    .y_dut(yd1), .y_ref(yr1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(ec1), .fail_a(fa1), .fail_diff(fd1)
  );

  issue_checker #(.AW(4), .YW(16), .CW(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(s3_start), .abort(s3_abort), .a(a3),
    .y_dut(yd3), .y_ref(yr3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(ec3), .fail_a(fa3), .fail_diff(fd3)
  );

  int          sel = 1;
  logic        cur_busy, cur_done, cur_pass;
  logic [3:0]  cur_a, cur_fa;
  logic [7:0]  cur_ec;
  logic [15:0] cur_fd;
  assign cur_busy = (sel == 3) ? busy3 : busy1;
  assign cur_done = (sel == 3) ? done3 : done1;
  assign cur_pass = (sel == 3) ? pass3 : pass1;
  assign cur_a    = (sel == 3) ? a3 : a1;
  assign cur_fa   = (sel == 3) ? fa3 : fa1;
  assign cur_ec   = (sel == 3) ? {6'd0, ec3} : ec1;
  assign cur_fd   = (sel == 3) ? fd3 : fd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_start(input int s, input logic v, input logic ab);
    if (s == 3) begin
      s3_start = v; s3_abort = ab;
    end else begin
      s1_start = v; s1_abort = ab;
    end
  endtask

  // One full sweep: queue the model's prediction, run, compare at done.
  task automatic run_sweep(input int s, input int mode, input bit with_abort, input bit poke_start);
    exp_t e, got;
    int   settle, cmax, cnt, n;
    logic [15:0] m;
    sel    = s;
    settle = (s == 3) ? 3 : 1;
    cmax   = (s == 3) ? 3 : 255;
    if (s == 3) mode3 = mode; else mode1 = mode;
    cnt = 0; e.fa = 0; e.fd = 0;
    for (int v = 0; v < 16; v++) begin
      m = mask_of(mode, 4'(v));
      if (m != 16'h0) begin
        if (cnt == 0) begin
          e.fa = v; e.fd = int'(m);
        end
        if (cnt < cmax) cnt++;
      end
    end
    e.err    = cnt;
    e.pass   = (cnt == 0) ? 1 : 0;
    e.cycles = 16 * settle;
    sb_q.push_back(e);

    @(negedge clk);
    drive_start(s, 1'b1, with_abort);
    @(negedge clk);
    drive_start(s, 1'b0, 1'b0);
    check("run_clr_err", cur_ec, 0);
    check("run_clr_fa", cur_fa, 0);
    check("run_clr_fd", cur_fd, 0);
    check("run_done_lo", cur_done, 0);
    n = 0;
    while (cur_busy && n < 200) begin
      check("a_step", cur_a, n / settle);
      drive_start(s, (poke_start && n == 4), 1'b0);
      n++;
      @(negedge clk);
    end
    drive_start(s, 1'b0, 1'b0);
    got = sb_q.pop_front();
    check("sweep_len", n, got.cycles);
    check("done", cur_done, 1);
    check("pass", cur_pass, got.pass);
    check("err_cnt", cur_ec, got.err);
    check("fail_a", cur_fa, got.fa);
    check("fail_diff", cur_fd, got.fd);
    check("a_hold", cur_a, 15);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", busy1 | busy3, 0);
    check("rst_done", done1 | done3, 0);
    check("rst_pass", pass1 | pass3, 0);
    check("rst_a", {a1, a3}, 0);
    check("rst_err", {ec1, ec3}, 0);
    check("rst_fail", {fa1, fa3, fd1, fd3}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // SETTLE=3: single mismatch at a==5, then saturation with every vector wrong.
    run_sweep(3, 1, 1'b0, 1'b0);
    run_sweep(3, 2, 1'b0, 1'b0);

    // SETTLE=1 clean sweep with a stray start mid-run that must be ignored.
    run_sweep(1, 0, 1'b0, 1'b1);
    s1_abort = 1'b1;
    @(negedge clk);
    s1_abort = 1'b0;
    check("abort_done_state", done1, 1);
    check("abort_done_pass", pass1, 1);

    // Mismatch only on the final compare.
    run_sweep(1, 3, 1'b0, 1'b0);

    // Abort on the compare cycle of a==7 while a mismatch is present.
    sel = 1; mode1 = 4;
    @(negedge clk);
    s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    for (int k = 0; k < 40 && a1 != 4'd7; k++) @(negedge clk);
    check("abort_reach", a1, 7);
    s1_abort = 1'b1;
    @(negedge clk);
    check("abort_busy", busy1, 0);
    check("abort_done", done1, 0);
    check("abort_pass", pass1, 0);
    check("abort_err", ec1, 1);
    check("abort_fa", fa1, 3);
    check("abort_fd", fd1, 16'h0010);
    check("abort_a", a1, 7);
    @(negedge clk);
    s1_abort = 1'b0;
    check("abort_idle_busy", busy1, 0);
    check("abort_idle_err", ec1, 1);

    // Start and abort together from IDLE: start wins, results cleared.
    run_sweep(1, 0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a sweep.
    mode1 = 0;
    @(negedge clk);
    s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    mode1 = 2;
    for (int k = 0; k < 40 && a1 != 4'd9; k++) @(negedge clk);
    check("rst_reach", a1, 9);
    check("rst_pre_err", ec1, 9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy1, 0);
    check("arst_done", done1, 0);
    check("arst_pass", pass1, 0);
    check("arst_a", a1, 0);
    check("arst_err", ec1, 0);
    check("arst_fail", {fa1, fd1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
